dump_tx: RTL and testbench
==========================

Name: dump_tx

Overview:
- Downstream consumer of the capture/dump controller.
- On each send_dump request it latches the RAM read-data byte and serialises it as a UART 8N1 frame on tx.
- When the stop bit completes it returns a single-cycle dump_sent pulse, which advances the controller to the next address.
- It also keeps a per-dump byte count, which dump_finished clears.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- CNT_W, 10, width of byte_cnt; must hold 512 samples.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- send_dump  input  1  request to transmit rdata; may be held high across several cycles
- rdata  input  8  RAM read data; sampled only in the accept cycle
- dump_finished  input  1  single-cycle pulse marking the end of a dump
- dump_sent  output  1  single-cycle pulse: the byte's stop bit has completed
- tx  output  1  UART serial out; idle high
- tx_busy  output  1  high from the accept cycle until dump_sent is pulsed, inclusive
- byte_cnt  output  CNT_W  bytes completed since the last dump_finished

Behaviour:
- Reset (async, any state, including mid-frame):
  - state = IDLE; tx = 1; dump_sent = 0; tx_busy = 0; byte_cnt = 0; baud and bit counters = 0.
  - A frame cut off by reset is abandoned; no dump_sent is issued for it.
- All outputs are registered.
- States: IDLE, START, DATA, STOP, DONE; plus PARITY only with the optional feature.
- IDLE:
  - On send_dump = 1: latch rdata into shift register; clear baud counter and bit index; go to START. This cycle is the accept cycle.
  - On send_dump = 0: stay in IDLE.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - First cycle of tx = 0 is the cycle after the accept cycle.
- DATA:
  - Bits sent LSB first, each for CLKS_PER_BIT cycles.
  - Bit index 0..7; after bit 7 go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles, then go to DONE.
- DONE: lasts exactly one cycle.
  - dump_sent = 1; tx = 1; byte_cnt increments (wraps modulo 2^CNT_W); next state IDLE.
  - send_dump is ignored in DONE, so a level still held over from the request cannot re-trigger a send.
- Baud counter counts 0..CLKS_PER_BIT-1; each terminal count advances the bit.
- Frame length: 10*CLKS_PER_BIT cycles of tx. dump_sent rises 10*CLKS_PER_BIT+1 cycles after the accept cycle.
- send_dump in START/DATA/STOP: ignored. rdata changes after the accept cycle do not affect the frame.
- dump_finished:
  - Clears byte_cnt to 0 the next cycle; does not abort a frame in flight.
  - If it coincides with DONE, clear wins: byte_cnt = 0.
- Back-to-back: the earliest next accept is the cycle after DONE, so there is at least one idle-high cycle between frames.

Optional Feature:
- Macro: DUMP_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles; dump_sent at 11*CLKS_PER_BIT+1 cycles after accept.
- Undefined: PARITY state and the parity logic are absent; 8N1 framing as above.

Test Plan:
- Reset: rst_n low mid-DATA (CLKS_PER_BIT=4) -> tx = 1, tx_busy = 0, byte_cnt = 0 immediately; no dump_sent ever follows.
- Single byte (CLKS_PER_BIT=4): send_dump pulse with rdata = 0xA5 -> tx, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1; dump_sent high for exactly one cycle, 41 cycles after accept; byte_cnt = 1.
- Held request: send_dump held high from accept until dump_sent, rdata changed to 0xFF after accept -> exactly one frame, carrying 0xA5; no second frame starts in DONE.
- Burst: 512 back-to-back requests, controller-style handshake -> 512 dump_sent pulses; byte_cnt = 512; each gap between frames is at least 1 idle-high cycle.
- dump_finished coinciding with DONE -> byte_cnt = 0 on the next cycle; dump_sent still pulses.
- With DUMP_TX_PARITY_EN, rdata = 0x07 -> parity bit = 1; dump_sent 45 cycles after accept (CLKS_PER_BIT=4).

Source files
------------

// File: rtl/dump_tx.sv
// dump_tx: serialises one RAM byte per send_dump request as a UART frame and pulses dump_sent when its stop bit completes.
// Optional even-parity bit between data and stop is enabled by defining DUMP_TX_PARITY_EN.
module dump_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             send_dump,
   input  logic [7:0]       rdata,
   input  logic             dump_finished,
   output logic             dump_sent,
   output logic             tx,
   output logic             tx_busy,
   output logic [CNT_W-1:0] byte_cnt
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef DUMP_TX_PARITY_EN
      PARITY,
`endif
      STOP,
      DONE
   } state_t;

`ifdef DUMP_TX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        data_q, data_d;
   logic              tx_d, busy_d, sent_d;
   logic [CNT_W-1:0]  cnt_d;
   logic              baud_tc;

   assign baud_tc = (baud_q == BAUD_LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         tx        <= 1'b1;
         tx_busy   <= 1'b0;
         dump_sent <= 1'b0;
         byte_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         tx        <= tx_d;
         tx_busy   <= busy_d;
         dump_sent <= sent_d;
         byte_cnt  <= cnt_d;
      end
   end

   // NOTE: every signal driven here gets a hold-value default first, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;

      // Every timed state shares one baud counter that wraps on each bit boundary.
      if (state_q != IDLE && state_q != DONE) begin
         baud_d = baud_tc ? '0 : baud_q + BAUD_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (send_dump) begin
               data_d  = rdata;
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_tc) state_d = DATA;
         end
         DATA: begin
            if (baud_tc) begin
               if (bit_q == 3'd7) state_d = AFTER_DATA;
               else               bit_d   = bit_q + 3'd1;
            end
         end
`ifdef DUMP_TX_PARITY_EN
         PARITY: begin
            if (baud_tc) state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_tc) state_d = DONE;
         end
         DONE: begin
            // A send_dump level still held from this request is deliberately ignored here.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so that the registered copies line up with it.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[bit_d];
`ifdef DUMP_TX_PARITY_EN
         PARITY:  tx_d = ^data_d;
`endif
         default: tx_d = 1'b1;
      endcase

      busy_d = (state_d != IDLE);
      sent_d = (state_d == DONE);

      // The byte is counted on leaving DONE, so a coincident dump_finished takes priority.
      if (dump_finished)         cnt_d = '0;
      else if (state_q == DONE)  cnt_d = byte_cnt + CNT_W'(1);
      else                       cnt_d = byte_cnt;
   end

endmodule

// File: tb/tb_dump_tx.sv
// tb_dump_tx: randomized scoreboard bench for dump_tx; expected frames come from a bit-level UART framing model.
// Build with DUMP_TX_PARITY_EN defined to exercise the parity frame format.
`timescale 1ns/1ps
module tb_dump_tx;

   localparam int C     = 4;
   localparam int CNT_W = 10;
`ifdef DUMP_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * C;

   logic             clk           = 1'b0;
   logic             rst_n         = 1'b0;
   logic             send_dump     = 1'b0;
   logic [7:0]       rdata         = 8'h00;
   logic             dump_finished = 1'b0;
   logic             dump_sent;
   logic             tx;
   logic             tx_busy;
   logic [CNT_W-1:0] byte_cnt;

   dump_tx #(.CLKS_PER_BIT(C), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .send_dump     (send_dump),
      .rdata         (rdata),
      .dump_finished (dump_finished),
      .dump_sent     (dump_sent),
      .tx            (tx),
      .tx_busy       (tx_busy),
      .byte_cnt      (byte_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         acc;
      logic [7:0] data;
   } req_t;

   req_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_issued = 0;
   int   n_pulses = 0;
   int   n_frames = 0;
   int   exp_cnt  = 0;
   logic mon_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dump_sent === 1'b1) n_pulses++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Line level of bit slot i of a frame: start, eight data bits LSB first, optional even parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[3'(i - 1)];
      if (NB == 11 && i == 9) return ^d;
      return 1'b1;
   endfunction

   // Monitor: every frame on tx is matched against the oldest outstanding request.
   initial begin : monitor
      req_t e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && tx === 1'b0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 32'(tx), 32'(1));
            end else begin
               e = sb_q.pop_front();
               check("start_cycle", cyc, e.acc + 1);
               for (int i = 0; i < FRAME; i++) begin
                  if (i != 0) @(negedge clk);
                  check("frame_busy_sent_tx", 32'({tx_busy, dump_sent, tx}),
                        32'({2'b10, frame_bit(e.data, i / C)}));
               end
               @(negedge clk);
               check("done_busy_sent_tx", 32'({tx_busy, dump_sent, tx}), 32'(3'b111));
               check("done_cycle", cyc, e.acc + FRAME + 1);
               n_frames++;
               @(negedge clk);
               check("gap_busy_sent_tx", 32'({tx_busy, dump_sent, tx}), 32'(3'b001));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] b);
      send_dump = 1'b1;
      rdata     = b;
      sb_q.push_back('{acc: cyc, data: b});
      n_issued++;
   endtask

   task automatic wait_sent();
      int k = 0;
      while (dump_sent !== 1'b1 && k < FRAME + 8) begin
         @(negedge clk);
         k++;
      end
      if (dump_sent !== 1'b1) check("sent_timeout", 32'(dump_sent), 32'(1));
   endtask

   task automatic check_cnt(input string name);
      check(name, 32'(byte_cnt), exp_cnt % (1 << CNT_W));
   endtask

   // Single-cycle request; rdata is scrambled right after the accept cycle.
   task automatic send_pulse(input logic [7:0] b);
      issue(b);
      tick();
      send_dump = 1'b0;
      rdata     = 8'($urandom);
      wait_sent();
      tick();
      exp_cnt++;
   endtask

   // Controller-style request held until dump_sent; last=0 leaves it high for a back-to-back follow-up.
   task automatic send_held(input logic [7:0] b, input logic [7:0] after, input bit last);
      issue(b);
      tick();
      rdata = after;
      wait_sent();
      tick();
      if (last) send_dump = 1'b0;
      exp_cnt++;
   endtask

   task automatic pulse_finished();
      dump_finished = 1'b1;
      tick();
      dump_finished = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin : stimulus
      logic tx_low;
      int   k;

      #12;
      check("reset_tx", 32'(tx), 32'(1));
      check("reset_busy", 32'(tx_busy), 32'(0));
      check("reset_sent", 32'(dump_sent), 32'(0));
      check("reset_cnt", 32'(byte_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      mon_en = 1'b1;

      send_pulse(8'hA5);
      check_cnt("cnt_single");

      send_held(8'hA5, 8'hFF, 1'b1);
      check_cnt("cnt_held");
      repeat (3) tick();
      check("held_no_retrigger_busy", 32'(tx_busy), 32'(0));

      send_pulse(8'h07);
      check_cnt("cnt_parity_byte");

      // dump_finished during a frame clears the count but leaves the frame intact.
      issue(8'h3C);
      tick();
      send_dump = 1'b0;
      repeat (10) tick();
      pulse_finished();
      check_cnt("cnt_clear_midframe");
      wait_sent();
      tick();
      exp_cnt++;
      check_cnt("cnt_after_midframe_clear");

      // dump_finished in the DONE cycle wins over that cycle's increment.
      issue(8'h5A);
      tick();
      send_dump = 1'b0;
      wait_sent();
      check_cnt("cnt_in_done");
      dump_finished = 1'b1;
      tick();
      dump_finished = 1'b0;
      exp_cnt = 0;
      check_cnt("cnt_clear_in_done");

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) send_pulse(8'($urandom));
         else                           send_held(8'($urandom), 8'($urandom), 1'b1);
         check_cnt("cnt_random");
         repeat ($urandom_range(0, 3)) tick();
         if ($urandom_range(0, 5) == 0) begin
            pulse_finished();
            check_cnt("cnt_random_clear");
         end
      end

      pulse_finished();
      for (int i = 0; i < 512; i++) send_held(8'($urandom), 8'($urandom), i == 511);
      check_cnt("cnt_burst_512");

      // Reset in the middle of the data bits abandons the frame.
      mon_en = 1'b0;
      issue(8'hC3);
      tick();
      send_dump = 1'b0;
      repeat (3 * C) tick();
      check("pre_reset_busy", 32'(tx_busy), 32'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("midframe_reset_tx", 32'(tx), 32'(1));
      check("midframe_reset_busy", 32'(tx_busy), 32'(0));
      check("midframe_reset_sent", 32'(dump_sent), 32'(0));
      check("midframe_reset_cnt", 32'(byte_cnt), 32'(0));
      sb_q.delete();
      n_issued--;
      exp_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_low = 1'b0;
      repeat (FRAME + 10) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_low = 1'b1;
      end
      check("abandoned_frame_tx_idle", 32'(tx_low), 32'(0));
      tick();
      mon_en = 1'b1;

      send_pulse(8'h81);
      check_cnt("cnt_after_reset");

      k = 0;
      while (sb_q.size() != 0 && k < 2 * FRAME) begin
         tick();
         k++;
      end
      repeat (4) tick();
      check("scoreboard_drained", sb_q.size(), 0);
      check("frames_seen", n_frames, n_issued);
      check("dump_sent_pulses", n_pulses, n_issued);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
